// File: rtl/tile_paint_ctrl.sv
// tile_paint_ctrl: write-side sequencer for the 270x270, 8-bit frame buffer.
// It accepts tile-paint and full-screen-clear commands over a valid/ready
// handshake and issues one frame-buffer write per clock.
// Optional build macro: TILE_BORDER_EN. When it is defined, the outer ring of
// every painted tile is written with BORDER_COLOR.
module tile_paint_ctrl #(
  parameter int          SCREEN_W     = 270,
  parameter int          SCREEN_H     = 270,
  parameter int          TILE_W       = 54,
  parameter int          TILE_H       = 54,
  parameter int          ADDR_W       = 17,
  parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_clear,
  input  logic [2:0]        req_col,
  input  logic [2:0]        req_row,
  input  logic [7:0]        req_color,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PXW = $clog2(TILE_W);
  localparam int PYW = $clog2(TILE_H);

  localparam logic [2:0]        GRID_COLS     = 3'(SCREEN_W / TILE_W);
  localparam logic [2:0]        GRID_ROWS     = 3'(SCREEN_H / TILE_H);
  localparam logic [PXW-1:0]    PX_LAST       = PXW'(TILE_W - 1);
  localparam logic [PYW-1:0]    PY_LAST       = PYW'(TILE_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP     = ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0] TILE_ROW_STEP = ADDR_W'(TILE_H * SCREEN_W);
  localparam logic [ADDR_W-1:0] TILE_COL_STEP = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] CLEAR_LAST    = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        color_q;
  logic [ADDR_W-1:0] line_base;
  logic [PXW-1:0]    px;
  logic [PYW-1:0]    py;

  logic [ADDR_W-1:0] tile_origin;
  logic              line_end;
  logic              tile_end;
  logic              index_bad;
  logic [PXW-1:0]    px_next;
  logic [PYW-1:0]    py_next;

  // Tile origin is computed once at acceptance from the requested indices;
  // the per-pixel address afterwards only ever adds 1 or a line step.
  always_comb begin
    tile_origin = ADDR_W'(req_row) * TILE_ROW_STEP + ADDR_W'(req_col) * TILE_COL_STEP;
    index_bad   = (req_col >= GRID_COLS) || (req_row >= GRID_ROWS);
    line_end    = (px == PX_LAST);
    tile_end    = line_end && (py == PY_LAST);
    px_next     = line_end ? '0 : px + PXW'(1);
    py_next     = line_end ? py + PYW'(1) : py;
  end

`ifdef TILE_BORDER_EN
  logic border_next;

  // The next pixel is on the tile's outer ring when either counter sits at an edge.
  always_comb begin
    border_next = (px_next == '0) || (px_next == PX_LAST) ||
                  (py_next == '0) || (py_next == PY_LAST);
  end
`else
  logic unused_border;

  // Without the border option the border colour has no role in the datapath.
  assign unused_border = ^BORDER_COLOR;
`endif

  // Command sequencer: every output is a register so the frame-buffer port
  // sees clean signals, and the first write lands the cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      color_q   <= '0;
      line_base <= '0;
      px        <= '0;
      py        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid && req_ready) begin
            color_q   <= req_color;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_clear) begin
              state   <= CLEAR;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= req_color;
            end else if (index_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= PAINT;
              wr_en     <= 1'b1;
              wr_addr   <= tile_origin;
              line_base <= tile_origin;
              px        <= '0;
              py        <= '0;
`ifdef TILE_BORDER_EN
              wr_data   <= BORDER_COLOR;
`else
              wr_data   <= req_color;
`endif
            end
          end
        end

        PAINT: begin
          if (tile_end) begin
            state <= DONE;
            wr_en <= 1'b0;
            done  <= 1'b1;
            px    <= '0;
            py    <= '0;
          end else begin
            px <= px_next;
            py <= py_next;
            if (line_end) begin
              line_base <= line_base + LINE_STEP;
              wr_addr   <= line_base + LINE_STEP;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
`ifdef TILE_BORDER_EN
            wr_data <= border_next ? BORDER_COLOR : color_q;
`else
            wr_data <= color_q;
`endif
          end
        end

        CLEAR: begin
          if (wr_addr == CLEAR_LAST) begin
            state <= DONE;
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_paint_ctrl.sv
// tb_tile_paint_ctrl: self-checking bench for tile_paint_ctrl. Expected write
// streams come from a pixel-level model of the frame (nested x/y loops).
module tb_tile_paint_ctrl;

  localparam int         SW = 270;
  localparam int         SH = 270;
  localparam int         TW = 54;
  localparam int         TH = 54;
  localparam int         AW = 17;
  localparam int         GRID = 5;
  localparam logic [7:0] BC = 8'h00;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_clear;
  logic [2:0]    req_col;
  logic [2:0]    req_row;
  logic [7:0]    req_color;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic          err;

  tile_paint_ctrl #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TILE_W(TW), .TILE_H(TH),
    .ADDR_W(AW), .BORDER_COLOR(BC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_clear(req_clear),
    .req_col(req_col), .req_row(req_row), .req_color(req_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    bit         clear;
    int         col;
    int         row;
    logic [7:0] color;
    int         exp_writes;
    int         exp_err;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t       tbl[7];
  int         compared = 0;
  int         mismatched = 0;
  int         exp_addr[$];
  logic [7:0] exp_data[$];

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a single line when it disagrees.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pixel-level model: the frame-buffer writes a command should produce, in order.
  task automatic buildModel(input bit clear, input int col, input int row, input logic [7:0] color);
    exp_addr.delete();
    exp_data.delete();
    if (clear) begin
      for (int a = 0; a < SW * SH; a++) begin
        exp_addr.push_back(a);
        exp_data.push_back(color);
      end
    end else if (col < GRID && row < GRID) begin
      for (int y = 0; y < TH; y++) begin
        for (int x = 0; x < TW; x++) begin
          bit edge_px;
          edge_px = (x == 0) || (x == TW - 1) || (y == 0) || (y == TH - 1);
          exp_addr.push_back((row * TH + y) * SW + col * TW + x);
`ifdef TILE_BORDER_EN
          exp_data.push_back(edge_px ? BC : color);
`else
          exp_data.push_back(edge_px ? color : color);
`endif
        end
      end
    end
  endtask

  // Present a command at the current negedge, wait for acceptance, then drop
  // valid and scramble the fields so only latched values can matter.
  task automatic applyStimulus(input bit clear, input int col, input int row, input logic [7:0] color);
    int n;
    req_valid = 1'b1;
    req_clear = clear;
    req_col   = 3'(col);
    req_row   = 3'(row);
    req_color = color;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_clear = 1'($urandom_range(0, 1));
    req_col   = 3'($urandom_range(0, 7));
    req_row   = 3'($urandom_range(0, 7));
    req_color = 8'($urandom_range(0, 255));
  endtask

  // Run one command end to end and compare the observed stream with the model.
  task automatic runCommand(input string name, input bit clear, input int col, input int row,
                            input logic [7:0] color, input int exp_writes, input int exp_err,
                            output int first_addr, output int last_addr);
    int writes, seq_err, busy_err, first_cyc, done_cyc, err_seen;
    buildModel(clear, col, row, color);
    applyStimulus(clear, col, row, color);
    writes = 0; seq_err = 0; busy_err = 0; first_cyc = 0; done_cyc = 0; err_seen = 0;
    first_addr = -1; last_addr = -1;
    for (int k = 1; k <= exp_writes + 20 && done_cyc == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== 1'b1) busy_err++;
      if (wr_en === 1'b1) begin
        if (writes == 0) begin
          first_cyc  = k;
          first_addr = int'(wr_addr);
        end else if (k != first_cyc + writes) begin
          seq_err++;
        end
        if (writes < exp_addr.size()) begin
          if (int'(wr_addr) != exp_addr[writes] || wr_data !== exp_data[writes]) seq_err++;
        end else begin
          seq_err++;
        end
        if (int'(wr_addr) >= SW * SH) seq_err++;
        last_addr = int'(wr_addr);
        writes++;
      end
      if (done === 1'b1) begin
        done_cyc = k;
        err_seen = int'(err);
        if (wr_en === 1'b1) seq_err++;
      end else if (err === 1'b1) begin
        seq_err++;
      end
    end
    checkOutput({name, "_writes"}, writes, exp_writes);
    checkOutput({name, "_stream"}, seq_err, 0);
    checkOutput({name, "_busy"}, busy_err, 0);
    checkOutput({name, "_first_cycle"}, first_cyc, (exp_writes > 0) ? 1 : 0);
    checkOutput({name, "_done_cycle"}, done_cyc, exp_writes + 1);
    checkOutput({name, "_err"}, err_seen, exp_err);
    @(negedge clk);
    checkOutput({name, "_ready_after"}, int'(req_ready), 1);
    checkOutput({name, "_idle_after"}, int'({busy, done, err, wr_en}), 0);
  endtask

  initial begin
    int first_a, last_a, bad, n, col, row, ew, ee, fa;

    reset = 1'b1; req_valid = 1'b0; req_clear = 1'b0;
    req_col = 3'd0; req_row = 3'd0; req_color = 8'h00;

    tbl[0] = '{1'b0, 0, 0, 8'hE0, 2916, 0, 0, 14363};
    tbl[1] = '{1'b0, 4, 4, 8'h1C, 2916, 0, 58536, 72899};
    tbl[2] = '{1'b0, 5, 0, 8'hAA, 0, 1, -1, -1};
    tbl[3] = '{1'b0, 0, 7, 8'h5A, 0, 1, -1, -1};
    tbl[4] = '{1'b0, 4, 0, 8'h33, 2916, 0, 216, 14579};
    tbl[5] = '{1'b1, 6, 3, 8'h00, 72900, 0, 0, 72899};
    tbl[6] = '{1'b0, 7, 7, 8'hFF, 0, 1, -1, -1};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_req_ready", int'(req_ready), 1);
    checkOutput("rst_wr_en", int'(wr_en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_wr_addr", int'(wr_addr), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_addr !== '0) bad++;
    end
    checkOutput("idle_20_cycles", bad, 0);

    $display("[TB] table-driven commands");
    for (int i = 0; i < 7; i++) begin
      runCommand($sformatf("tbl%0d", i), tbl[i].clear, tbl[i].col, tbl[i].row, tbl[i].color,
                 tbl[i].exp_writes, tbl[i].exp_err, first_a, last_a);
      if (tbl[i].exp_first >= 0) begin
        checkOutput($sformatf("tbl%0d_first_addr", i), first_a, tbl[i].exp_first);
        checkOutput($sformatf("tbl%0d_last_addr", i), last_a, tbl[i].exp_last);
      end
    end

    $display("[TB] random paint commands");
    for (int i = 0; i < 4; i++) begin
      col = int'($urandom_range(0, 6));
      row = int'($urandom_range(0, 6));
      ew  = (col < GRID && row < GRID) ? TW * TH : 0;
      ee  = (ew == 0) ? 1 : 0;
      runCommand($sformatf("rnd%0d", i), 1'b0, col, row, 8'($urandom_range(0, 255)),
                 ew, ee, first_a, last_a);
      if (ew > 0) begin
        fa = row * TH * SW + col * TW;
        checkOutput($sformatf("rnd%0d_first_addr", i), first_a, fa);
        checkOutput($sformatf("rnd%0d_last_addr", i), last_a, fa + (TH - 1) * SW + TW - 1);
      end
    end

    $display("[TB] reset in the middle of a paint");
    applyStimulus(1'b0, 2, 3, 8'h55);
    n = 0;
    for (int k = 0; k < 200 && n < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (wr_en === 1'b1) n++;
    end
    checkOutput("abort_writes_before_reset", n, 100);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_wr_en_async", int'(wr_en), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_ready", int'(req_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || wr_en !== 1'b0) bad++;
    end
    checkOutput("abort_no_done", bad, 0);
    runCommand("after_abort", 1'b0, 1, 2, 8'hC3, TW * TH, 0, first_a, last_a);
    checkOutput("after_abort_first_addr", first_a, 29214);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tile_paint_ctrl.md
Name: tile_paint_ctrl

Overview:
Write-side sequencer for the 270x270, 8-bit-per-pixel dual-port frame buffer. Accepts tile-paint and full-screen-clear commands over a valid/ready handshake and generates one frame-buffer write per clock: address, data and write enable. It sits between the game/maze logic and the frame buffer write port; the VGA read side is untouched.

Parameters:
SCREEN_W, 270, frame width in pixels
SCREEN_H, 270, frame height in pixels
TILE_W, 54, tile width in pixels (grid columns = SCREEN_W/TILE_W = 5)
TILE_H, 54, tile height in pixels (grid rows = SCREEN_H/TILE_H = 5)
ADDR_W, 17, write address width; must be at least ceil(log2(SCREEN_W*SCREEN_H))
BORDER_COLOR, 8'h00, tile border colour (used only with TILE_BORDER_EN)

Ports:
clk  in  1  single system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  command valid
req_ready  out  1  controller can accept a command
req_clear  in  1  1 = clear whole screen, 0 = paint one tile
req_col  in  3  tile column index (paint only)
req_row  in  3  tile row index (paint only)
req_color  in  8  fill colour
wr_en  out  1  frame-buffer write enable
wr_addr  out  ADDR_W  frame-buffer write address, row-major (y*SCREEN_W + x)
wr_data  out  8  frame-buffer write data
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse, coincident with done, for a rejected tile index

Behaviour:
- Reset, asynchronous: state=IDLE; req_ready=1; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0; err=0; counters=0.
- Handshake: a command is accepted on a posedge where req_valid && req_ready. req_ready=1 only in IDLE. All req_* fields are latched at acceptance and ignored afterwards.
- States:
  - IDLE: on accept, go to CLEAR if req_clear=1.
  - IDLE: on accept with req_clear=0 and a valid index, go to PAINT.
  - IDLE: on accept with req_col>=5 or req_row>=5, go to DONE with err set.
  - PAINT or CLEAR: after the last write, go to DONE.
  - DONE: lasts one cycle with done=1, then return to IDLE.
- Outputs are registered. The first write appears the cycle after acceptance. Exactly one write per cycle, with no gaps.
- PAINT:
  - Counters px in 0..TILE_W-1 (inner) and py in 0..TILE_H-1 (outer).
  - wr_addr = (row*TILE_H+py)*SCREEN_W + col*TILE_W + px.
  - Compute the address incrementally: a line base register adds SCREEN_W per line. No per-pixel multiplier.
  - Writes TILE_W*TILE_H = 2916 pixels; wr_data = latched colour.
- CLEAR: wr_addr runs 0..SCREEN_W*SCREEN_H-1 (0..72899) sequentially with wr_data = latched colour; 72900 writes.
- DONE: wr_en=0, req_ready=0, done=1. wr_addr/wr_data hold their last values.
- After the DONE cycle the controller is back in IDLE. A command held valid is accepted at the end of that IDLE cycle, so consecutive commands are separated by exactly 2 idle write cycles.
- Rejected index: no writes at all. Acceptance is followed immediately by the DONE cycle, where done=1 and err=1.
- Reset mid-operation: the command is aborted, wr_en drops immediately (asynchronously) and no done pulse is issued. The partially painted region is left as is.
- Arithmetic: all address math is ADDR_W bits, unsigned, with no wrap. The maximum address is 72899, which fits in 17 bits.

Optional Feature:
TILE_BORDER_EN
- Defined: during PAINT, pixels with px==0, px==TILE_W-1, py==0 or py==TILE_H-1 are written with BORDER_COLOR; all other pixels use req_color. Write count and timing are unchanged, and CLEAR is unaffected.
- Undefined: every tile pixel is written with req_color, and the BORDER_COLOR parameter is unused.

Test Plan:
- Reset released, no request -> req_ready=1, wr_en=0, busy=0, done=0, wr_addr=0 for 20 cycles.
- Paint col=0 row=0 colour 8'hE0 -> writes begin the next cycle at addresses 0,1,...,53,270,...; last write 14363; exactly 2916 writes, all data E0; done pulses 1 cycle after the last write.
- Paint col=4 row=4 colour 8'h1C -> first address 58536, last 72899, 2916 writes; no address ever reaches 72900.
- Clear colour 8'h00 -> 72900 consecutive writes at addresses 0..72899; busy high throughout; one done pulse; err=0.
- Paint col=5 row=0 -> zero writes; done=1 and err=1 in the cycle after acceptance; req_ready returns 1 the cycle after that.
- Assert reset after 100 writes of a paint -> wr_en=0 immediately and no done pulse. A following paint col=1 row=2 -> first address 108*270+54=29214. With TILE_BORDER_EN defined, pixel (px=1,py=1) carries req_color and pixel (0,0) carries BORDER_COLOR.
